draw_cmd_scheduler: RTL and testbench

DRAW_CMD_SCHEDULER -- requirements
Module: draw_cmd_scheduler

---
 rtl/draw_cmd_scheduler.sv | 119 +++++++++++
 tb/tb_draw_cmd_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_cmd_scheduler.sv
// Two-source draw command scheduler: round-robin arbitration with half-command
// lock, single-cycle engine strobe and a bounded wait for engine completion.
module draw_cmd_scheduler #(
    parameter int unsigned             CMD_WIDTH = 32,
    parameter int unsigned             TMO_WIDTH = 16,
    parameter logic [TMO_WIDTH-1:0]    TMO_MAX   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_vld,
    input  logic [CMD_WIDTH-1:0] req0_cmd,
    output logic                 req0_rdy,
    input  logic                 req1_vld,
    input  logic [CMD_WIDTH-1:0] req1_cmd,
    output logic                 req1_rdy,
    output logic [CMD_WIDTH-1:0] eng_cmd,
    output logic                 eng_vld,
    input  logic                 eng_done,
    input  logic                 eng_half,
    output logic                 grant,
    output logic                 busy,
    output logic                 tmo_pulse,
    output logic                 tmo_flag
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t                 state;
    logic                   ptr;
    logic                   lock;
    logic [TMO_WIDTH-1:0]   tmo_cnt;

    logic                   sel;
    logic                   accept;
    logic [CMD_WIDTH-1:0]   sel_cmd;
    logic [3:0]             opcode;
    logic                   is_half;

    // While locked, ptr holds the locked source, so sel never leaves it.
    always_comb begin
        sel = ptr;
        if (!lock) begin
            if (req0_vld && !req1_vld)
                sel = 1'b0;
            else if (req1_vld && !req0_vld)
                sel = 1'b1;
        end
        req0_rdy = !rst && (state == IDLE) && !sel && req0_vld;
        req1_rdy = !rst && (state == IDLE) && sel && req1_vld;
        accept   = req0_rdy || req1_rdy;
        sel_cmd  = sel ? req1_cmd : req0_cmd;
        opcode   = sel_cmd[CMD_WIDTH-1:CMD_WIDTH-4];
        is_half  = ((opcode == 4'h9) || (opcode == 4'hA)) && !sel_cmd[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            lock      <= 1'b0;
            tmo_cnt   <= '0;
            eng_cmd   <= '0;
            eng_vld   <= 1'b0;
            grant     <= 1'b0;
            busy      <= 1'b0;
            tmo_pulse <= 1'b0;
            tmo_flag  <= 1'b0;
        end else begin
            eng_vld   <= 1'b0;
            tmo_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_cmd <= sel_cmd;
                        grant   <= sel;
                        eng_vld <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                        if (is_half) begin
                            lock <= 1'b1;
                            ptr  <= sel;
                        end else begin
                            lock <= 1'b0;
                            ptr  <= !sel;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (eng_done || eng_half) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_MAX) begin
                        busy      <= 1'b0;
                        tmo_pulse <= 1'b1;
                        tmo_flag  <= 1'b1;
                        lock      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Directed cycle table for draw_cmd_scheduler plus a hand sequence for
// asynchronous reset in the middle of a locked wait.
module tb_draw_cmd_scheduler;

    localparam logic [31:0] CA = 32'h0A52_8F00;
    localparam logic [31:0] CP = 32'h1000_0000;
    localparam logic [31:0] CQ = 32'h2000_0000;
    localparam logic [31:0] CH = 32'hA000_0000;
    localparam logic [31:0] CH1 = 32'hA000_0001;
    localparam logic [31:0] CT = 32'h3000_0000;
    localparam logic [31:0] CN = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [31:0] req0_cmd, req1_cmd;
    logic        req0_rdy, req1_rdy;
    logic [31:0] eng_cmd;
    logic        eng_vld, eng_done, eng_half;
    logic        grant, busy, tmo_pulse, tmo_flag;

    int total = 0;
    int bad = 0;

    draw_cmd_scheduler #(
        .CMD_WIDTH(32),
        .TMO_WIDTH(16),
        .TMO_MAX(16'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_vld(req0_vld),
        .req0_cmd(req0_cmd),
        .req0_rdy(req0_rdy),
        .req1_vld(req1_vld),
        .req1_cmd(req1_cmd),
        .req1_rdy(req1_rdy),
        .eng_cmd(eng_cmd),
        .eng_vld(eng_vld),
        .eng_done(eng_done),
        .eng_half(eng_half),
        .grant(grant),
        .busy(busy),
        .tmo_pulse(tmo_pulse),
        .tmo_flag(tmo_flag)
    );

    always #5 clk = ~clk;

    // e = {rdy0, rdy1, eng_vld, grant, busy, tmo_pulse, tmo_flag}
    typedef struct {
        logic        r;
        logic        v0;
        logic [31:0] c0;
        logic        v1;
        logic [31:0] c1;
        logic        d;
        logic        h;
        logic [6:0]  e;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v0, input logic [31:0] c0,
                       input logic v1, input logic [31:0] c1,
                       input logic d, input logic h,
                       input logic [6:0] e, input logic [31:0] ec);
        vec_t v;
        v = '{r, v0, c0, v1, c1, d, h, e, ec};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [6:0] outs();
        return {req0_rdy, req1_rdy, eng_vld, grant, busy, tmo_pulse, tmo_flag};
    endfunction

    initial begin
        rst = 1'b1;
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        req0_cmd = '0;
        req1_cmd = '0;
        eng_done = 1'b0;
        eng_half = 1'b0;

        // reset, then single source with done 4 cycles after eng_vld
        add(1, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        add(0, 1, CA, 0, 0, 0, 0, 7'b1000000, 0);
        add(0, 0, CA, 0, 0, 0, 0, 7'b0010100, CA);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 1, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        // contention, ptr=1: grants 1,0,1,0
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0100000, 0);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0011100, CQ);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0001100, 0);
        add(0, 1, CP, 1, CQ, 1, 0, 7'b0001100, 0);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b1001000, 0);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0010100, CP);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0000100, 0);
        add(0, 1, CP, 1, CQ, 1, 0, 7'b0000100, 0);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0100000, 0);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0011100, CQ);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b0001100, 0);
        add(0, 1, CP, 1, CQ, 1, 0, 7'b0001100, 0);
        add(0, 1, CP, 1, CQ, 0, 0, 7'b1001000, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0010100, CP);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 1, 0, 7'b0000100, 0);
        // lock: src1 half, src0 starved until src1's full command
        add(0, 1, CP, 1, CH, 0, 0, 7'b0100000, 0);
        add(0, 1, CP, 0, 0, 0, 0, 7'b0011100, CH);
        add(0, 1, CP, 0, 0, 0, 0, 7'b0001100, 0);
        add(0, 1, CP, 0, 0, 0, 1, 7'b0001100, 0);
        add(0, 1, CP, 0, 0, 0, 0, 7'b0001000, 0);
        add(0, 1, CP, 1, CH1, 0, 0, 7'b0101000, 0);
        add(0, 1, CP, 0, 0, 0, 1, 7'b0011100, CH1);
        add(0, 1, CP, 0, 0, 0, 0, 7'b0001100, 0);
        add(0, 1, CP, 0, 0, 1, 0, 7'b0001100, 0);
        add(0, 1, CP, 0, 0, 0, 0, 7'b1001000, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0010100, CP);
        add(0, 0, 0, 0, 0, 1, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        // timeout at tmo_cnt==8: pulse 9 cycles after WAIT entry
        add(0, 1, CT, 0, 0, 0, 0, 7'b1000000, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0010100, CT);
        for (int i = 0; i < 9; i++)
            add(0, 0, 0, 0, 0, 0, 0, 7'b0000100, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000011, 0);
        // done on the limit cycle wins over timeout
        add(0, 1, CT, 0, 0, 0, 0, 7'b1000001, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0010101, CT);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 0, 0, 0, 0, 7'b0000101, 0);
        add(0, 0, 0, 0, 0, 1, 0, 7'b0000101, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000001, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7'b0000001, 0);

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r;
            req0_vld = tbl[i].v0;
            req0_cmd = tbl[i].c0;
            req1_vld = tbl[i].v1;
            req1_cmd = tbl[i].c1;
            eng_done = tbl[i].d;
            eng_half = tbl[i].h;
            #1;
            chk($sformatf("row%0d_outs", i), {25'd0, outs()}, {25'd0, tbl[i].e});
            if (tbl[i].e[4])
                chk($sformatf("row%0d_cmd", i), eng_cmd, tbl[i].ec);
            @(posedge clk);
            #1;
        end

        // locked half from src1 (ptr=1), then reset while waiting
        req0_vld = 1'b0;
        req1_vld = 1'b1;
        req1_cmd = CN;
        eng_done = 1'b0;
        eng_half = 1'b0;
        #1;
        chk("lk_rdy1", {31'd0, req1_rdy}, 32'd1);
        @(posedge clk);
        #1;
        req1_vld = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("lk_busy", {31'd0, busy}, 32'd1);
        req0_vld = 1'b1;
        req0_cmd = CP;
        req1_vld = 1'b1;
        req1_cmd = CQ;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outs", {25'd0, outs()}, 32'd0);
        chk("rst_cmd", eng_cmd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", {30'd0, req0_rdy, req1_rdy}, 32'd2);
        @(posedge clk);
        #1;
        chk("post_rst_vld_g", {30'd0, eng_vld, grant}, 32'd2);
        chk("post_rst_cmd", eng_cmd, CP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
